// File: rtl/door_interlock_if.sv
// Signal bundle between the door switches / oven controller and the door interlock.
// Carries the conditioned door status back to the oven FSM.
interface door_interlock_if #(
    parameter int N_SENSORS = 2
);
    logic [N_SENSORS-1:0] sensor_raw;
    logic                 lock_req;
    logic                 fault_clr;
    logic                 door_closed;
    logic                 door_locked;
    logic                 lock_ack;
    logic                 open_evt;
    logic                 fault;
    logic [N_SENSORS-1:0] deb_state;
    logic [2:0]           fsm_state;

    // lock_req is a level held by the oven controller for as long as it wants the
    // door locked; lock_ack pulses for one cycle on entry to LOCKED and door_locked
    // holds while locked. Dropping lock_req releases the lock.
    modport master (
        output sensor_raw, lock_req, fault_clr,
        input  door_closed, door_locked, lock_ack, open_evt, fault, deb_state, fsm_state
    );

    modport slave (
        input  sensor_raw, lock_req, fault_clr,
        output door_closed, door_locked, lock_ack, open_evt, fault, deb_state, fsm_state
    );
endinterface

// File: rtl/door_interlock_ctrl.sv
// Redundant door switch conditioning (sync, debounce, cross-check) feeding a
// lock/interlock state machine consumed by the oven heating controller.
module door_interlock_ctrl #(
    parameter int N_SENSORS       = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DISAGREE_LIMIT  = 32,
    parameter int LOCK_DELAY      = 8
) (
    input logic             clk,
    input logic             reset,
    door_interlock_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int DIS_W = $clog2(DISAGREE_LIMIT + 1);
    localparam int TMR_W = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIS_W-1:0] DIS_MAX  = DIS_W'(DISAGREE_LIMIT);
    localparam logic [DIS_W-1:0] DIS_LAST = DIS_W'(DISAGREE_LIMIT - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_DELAY - 1);

    typedef enum logic [2:0] {
        ST_OPEN    = 3'd0,
        ST_CLOSED  = 3'd1,
        ST_LOCKING = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    logic [N_SENSORS-1:0] sync1;
    logic [N_SENSORS-1:0] sync2;
    logic [N_SENSORS-1:0] deb;
    logic [CNT_W-1:0]     deb_cnt [N_SENSORS];
    logic [DIS_W-1:0]     dis_cnt;

    logic all_closed;
    logic all_open;
    logic mixed;
    logic dis_hit;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic             ack_nxt;
    logic             evt_nxt;

    logic closed_q;
    logic locked_q;
    logic ack_q;
    logic evt_q;
    logic fault_q;

    // A channel flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < N_SENSORS; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= bus.sensor_raw;
            sync2 <= sync1;
            for (int i = 0; i < N_SENSORS; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= ~deb[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign all_closed = &deb;
    assign all_open   = ~|deb;
    assign mixed      = !(all_closed || all_open);
    // Fires on the edge at which the disagreement count reaches the limit.
    assign dis_hit    = mixed && (dis_cnt >= DIS_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            dis_cnt <= '0;
        end else if (mixed) begin
            if (dis_cnt != DIS_MAX) dis_cnt <= dis_cnt + DIS_W'(1);
        end else begin
            dis_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        ack_nxt   = 1'b0;
        evt_nxt   = 1'b0;
        if (dis_hit) begin
            state_nxt = ST_FAULT;
            evt_nxt   = (state == ST_CLOSED) || (state == ST_LOCKING) || (state == ST_LOCKED);
        end else begin
            case (state)
                ST_OPEN: begin
                    if (all_closed) state_nxt = ST_CLOSED;
                end
                ST_CLOSED: begin
                    if (all_open) begin
                        state_nxt = ST_OPEN;
                        evt_nxt   = 1'b1;
                    end else if (bus.lock_req) begin
                        state_nxt = ST_LOCKING;
                        timer_nxt = TMR_LOAD;
                    end
                end
                ST_LOCKING: begin
                    if (!all_closed) begin
                        state_nxt = ST_OPEN;
                        evt_nxt   = 1'b1;
                    end else if (!bus.lock_req) begin
                        state_nxt = ST_CLOSED;
                    end else if (timer == '0) begin
                        state_nxt = ST_LOCKED;
                        ack_nxt   = 1'b1;
                    end else begin
                        timer_nxt = timer - TMR_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Any channel opening while locked means tamper or a failed lock.
                    if (!all_closed) begin
                        state_nxt = ST_FAULT;
                        evt_nxt   = 1'b1;
                    end else if (!bus.lock_req) begin
                        state_nxt = ST_CLOSED;
                    end
                end
                ST_FAULT: begin
                    if (bus.fault_clr && all_closed) state_nxt = ST_CLOSED;
                    else if (bus.fault_clr && all_open) state_nxt = ST_OPEN;
                end
                default: state_nxt = ST_OPEN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_OPEN;
            timer    <= '0;
            closed_q <= 1'b0;
            locked_q <= 1'b0;
            ack_q    <= 1'b0;
            evt_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            closed_q <= (state_nxt == ST_CLOSED) || (state_nxt == ST_LOCKING) ||
                        (state_nxt == ST_LOCKED);
            locked_q <= (state_nxt == ST_LOCKED);
            ack_q    <= ack_nxt;
            evt_q    <= evt_nxt;
            fault_q  <= (state_nxt == ST_FAULT);
        end
    end

    assign bus.door_closed = closed_q;
    assign bus.door_locked = locked_q;
    assign bus.lock_ack    = ack_q;
    assign bus.open_evt    = evt_q;
    assign bus.fault       = fault_q;
    assign bus.deb_state   = deb;
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_door_interlock_ctrl.sv
// Directed bench for door_interlock_ctrl with N=2, debounce 4, disagree limit 8,
// lock delay 3: a vector table for the main flow plus hand-written corner sequences.
module tb_door_interlock_ctrl;
    localparam int N = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    door_interlock_if #(.N_SENSORS(N)) bus ();

    door_interlock_ctrl #(
        .N_SENSORS      (N),
        .DEBOUNCE_CYCLES(4),
        .DISAGREE_LIMIT (8),
        .LOCK_DELAY     (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0] raw;
        logic       lock_req;
        logic       fault_clr;
        int         n;
        logic [1:0] deb;
        logic       closed;
        logic       locked;
        logic       ack;
        logic       evt;
        logic       flt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic [1:0] deb, input logic closed,
                              input logic locked, input logic ack, input logic evt,
                              input logic flt);
        check({tag, " deb_state"},   8'(bus.deb_state),   8'(deb));
        check({tag, " door_closed"}, 8'(bus.door_closed), 8'(closed));
        check({tag, " door_locked"}, 8'(bus.door_locked), 8'(locked));
        check({tag, " lock_ack"},    8'(bus.lock_ack),    8'(ack));
        check({tag, " open_evt"},    8'(bus.open_evt),    8'(evt));
        check({tag, " fault"},       8'(bus.fault),       8'(flt));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic vec_t mk(input logic [1:0] raw, input logic lr, input logic fc,
                                input int n, input logic [1:0] deb, input logic closed,
                                input logic locked, input logic ack, input logic evt,
                                input logic flt);
        vec_t v;
        v.raw = raw; v.lock_req = lr; v.fault_clr = fc; v.n = n;
        v.deb = deb; v.closed = closed; v.locked = locked;
        v.ack = ack; v.evt = evt; v.flt = flt;
        return v;
    endfunction

    initial begin
        // Each row: drive inputs, advance n edges, then compare outputs.
        vecs.push_back(mk(2'b11, 0, 0, 5, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 0, 0, 1, 2'b11, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 0, 0, 1, 2'b11, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 1, 0, 3, 2'b11, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 1, 0, 1, 2'b11, 1, 1, 1, 0, 0));
        vecs.push_back(mk(2'b11, 1, 0, 1, 2'b11, 1, 1, 0, 0, 0));
        vecs.push_back(mk(2'b11, 0, 0, 1, 2'b11, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 1, 0, 4, 2'b11, 1, 1, 1, 0, 0));
        vecs.push_back(mk(2'b00, 1, 0, 5, 2'b11, 1, 1, 0, 0, 0));
        vecs.push_back(mk(2'b00, 1, 0, 1, 2'b00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(2'b00, 1, 0, 1, 2'b00, 0, 0, 0, 1, 1));
        vecs.push_back(mk(2'b00, 1, 0, 1, 2'b00, 0, 0, 0, 0, 1));
        vecs.push_back(mk(2'b00, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 2, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 0, 0, 6, 2'b11, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 0, 0, 1, 2'b11, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 6, 2'b00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 1, 0, 1, 2'b00, 0, 0, 0, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));

        bus.sensor_raw = 2'b00;
        bus.lock_req   = 1'b0;
        bus.fault_clr  = 1'b0;
        reset          = 1'b1;
        tick(3);
        check_outs("reset", 2'b00, 0, 0, 0, 0, 0);
        check("reset fsm_state", 8'(bus.fsm_state), 8'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            bus.sensor_raw = vecs[i].raw;
            bus.lock_req   = vecs[i].lock_req;
            bus.fault_clr  = vecs[i].fault_clr;
            tick(vecs[i].n);
            check_outs($sformatf("vec%0d", i), vecs[i].deb, vecs[i].closed, vecs[i].locked,
                       vecs[i].ack, vecs[i].evt, vecs[i].flt);
        end

        // Glitches of 3 cycles never reach the 4-sample debounce threshold.
        for (int k = 0; k < 5; k++) begin
            bus.sensor_raw = 2'b11;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                check($sformatf("glitch%0d_hi deb", k), 8'(bus.deb_state), 8'd0);
                check($sformatf("glitch%0d_hi closed", k), 8'(bus.door_closed), 8'd0);
            end
            bus.sensor_raw = 2'b00;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                check($sformatf("glitch%0d_lo deb", k), 8'(bus.deb_state), 8'd0);
                check($sformatf("glitch%0d_lo closed", k), 8'(bus.door_closed), 8'd0);
            end
        end
        tick(3);

        // Channel disagreement from CLOSED escalates to FAULT.
        bus.sensor_raw = 2'b11;
        tick(7);
        check("dis_pre closed", 8'(bus.door_closed), 8'd1);
        bus.sensor_raw = 2'b01;
        tick(5);
        check("dis_e5 deb", 8'(bus.deb_state), 8'h3);
        tick(1);
        check("dis_e6 deb", 8'(bus.deb_state), 8'h1);
        tick(7);
        check_outs("dis_e13", 2'b01, 1, 0, 0, 0, 0);
        tick(1);
        check_outs("dis_e14", 2'b01, 0, 0, 0, 1, 1);
        tick(1);
        check_outs("dis_e15", 2'b01, 0, 0, 0, 0, 1);
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        check_outs("dis_clr_mixed", 2'b01, 0, 0, 0, 0, 1);
        check("dis_clr_mixed fsm_state", 8'(bus.fsm_state), 8'd4);
        bus.sensor_raw = 2'b11;
        tick(6);
        check_outs("dis_agree", 2'b11, 0, 0, 0, 0, 1);
        tick(1);
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        check_outs("dis_clr_closed", 2'b11, 1, 0, 0, 0, 0);

        // Reset while LOCKING with one cycle left on the timer.
        bus.lock_req = 1'b1;
        tick(2);
        check("rst_pre fsm_state", 8'(bus.fsm_state), 8'd2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_outs("rst_locking", 2'b00, 0, 0, 0, 0, 0);
        check("rst_locking fsm_state", 8'(bus.fsm_state), 8'd0);
        tick(5);
        check_outs("rst_e5", 2'b00, 0, 0, 0, 0, 0);
        tick(1);
        check_outs("rst_e6", 2'b11, 0, 0, 0, 0, 0);
        tick(1);
        check_outs("rst_e7", 2'b11, 1, 0, 0, 0, 0);
        tick(3);
        check_outs("rst_e10", 2'b11, 1, 0, 0, 0, 0);
        tick(1);
        check_outs("rst_e11", 2'b11, 1, 1, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
